// File: rtl/handshake_prop_monitor.sv
// handshake_prop_monitor: req|=>ack (intr abort) and a[*MIN_RUN:$] ##1 b monitor; FIRST_VIOL_STAMP_EN adds first-violation stamp
module handshake_prop_monitor #(
  parameter int CNT_W = 16,
  parameter int RUN_W = 8,
  parameter int MIN_RUN = 1
`ifdef FIRST_VIOL_STAMP_EN
  , parameter int STAMP_W = 32
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             req,
  input  logic             ack,
  input  logic             intr,
  input  logic             seq_a,
  input  logic             seq_b,
  output logic             pend,
  output logic             viol,
  output logic [CNT_W-1:0] viol_cnt,
  output logic             cover_hit,
  output logic [CNT_W-1:0] cover_cnt,
  output logic [RUN_W-1:0] last_run
`ifdef FIRST_VIOL_STAMP_EN
  , output logic               first_viol_vld,
  output logic [STAMP_W-1:0] first_viol_cycle
`endif
);
  localparam logic IDLE = 1'b0;
  localparam logic RUN = 1'b1;
  localparam logic [RUN_W-1:0] MIN_R = RUN_W'(MIN_RUN);
  logic state;
  logic [RUN_W-1:0] run_cnt;
  logic viol_d, match;
  always_comb begin
    viol_d = pend && !ack && !intr;
    match = state == RUN && seq_b && run_cnt >= MIN_R;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= 1'b0;
      viol <= 1'b0;
      cover_hit <= 1'b0;
      state <= IDLE;
      run_cnt <= '0;
      viol_cnt <= '0;
      cover_cnt <= '0;
      last_run <= '0;
    end else begin
      pend <= req && en && !intr;
      viol <= viol_d;
      cover_hit <= match;
      state <= seq_a ? RUN : IDLE;
      run_cnt <= !seq_a ? '0 : state == IDLE ? RUN_W'(1) : run_cnt + RUN_W'(!(&run_cnt));
      viol_cnt <= clr ? '0 : viol_cnt + CNT_W'(viol_d && !(&viol_cnt));
      cover_cnt <= clr ? '0 : cover_cnt + CNT_W'(match && !(&cover_cnt));
      last_run <= clr ? '0 : match ? run_cnt : last_run;
    end
  end
`ifdef FIRST_VIOL_STAMP_EN
  logic [STAMP_W-1:0] stamp;
  always_ff @(posedge clk) begin
    if (rst) begin
      stamp <= '0;
      first_viol_vld <= 1'b0;
      first_viol_cycle <= '0;
    end else begin
      stamp <= stamp + STAMP_W'(1);
      if (clr) begin
        first_viol_vld <= 1'b0;
        first_viol_cycle <= '0;
      end else if (viol && !first_viol_vld) begin
        first_viol_vld <= 1'b1;
        first_viol_cycle <= stamp;
      end
    end
  end
`endif
endmodule

// File: tb/tb_handshake_prop_monitor.sv
// tb_handshake_prop_monitor: scoreboard bench, CNT_W=2 RUN_W=4 MIN_RUN=3 to reach saturation and run thresholds
module tb_handshake_prop_monitor;
  localparam int VIOL = 0, PEND = 1, HIT = 2, VCNT = 3, CCNT = 4, LAST = 5, FVLD = 6, FCYC = 7;
  typedef struct {int at; int sel; int val; string nm;} exp_t;
  logic clk = 0, rst = 1, en = 1, clr = 0, req = 0, ack = 0, intr = 0, seq_a = 0, seq_b = 0;
  logic pend, viol, cover_hit;
  logic [1:0] viol_cnt, cover_cnt;
  logic [3:0] last_run;
`ifdef FIRST_VIOL_STAMP_EN
  logic first_viol_vld;
  logic [15:0] first_viol_cycle;
`endif
  int cyc = 0, checks = 0, failures = 0, rst_low = 0;
  int hist[0:1023][0:7];
  exp_t q[$];
  exp_t e;
  handshake_prop_monitor #(.CNT_W(2), .RUN_W(4), .MIN_RUN(3)
`ifdef FIRST_VIOL_STAMP_EN
    , .STAMP_W(16)
`endif
  ) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .req(req), .ack(ack), .intr(intr),
    .seq_a(seq_a), .seq_b(seq_b), .pend(pend), .viol(viol), .viol_cnt(viol_cnt),
    .cover_hit(cover_hit), .cover_cnt(cover_cnt), .last_run(last_run)
`ifdef FIRST_VIOL_STAMP_EN
    , .first_viol_vld(first_viol_vld), .first_viol_cycle(first_viol_cycle)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (cyc < 1024) begin
    hist[cyc][VIOL] = int'(viol);
    hist[cyc][PEND] = int'(pend);
    hist[cyc][HIT] = int'(cover_hit);
    hist[cyc][VCNT] = int'(viol_cnt);
    hist[cyc][CCNT] = int'(cover_cnt);
    hist[cyc][LAST] = int'(last_run);
`ifdef FIRST_VIOL_STAMP_EN
    hist[cyc][FVLD] = int'(first_viol_vld);
    hist[cyc][FCYC] = int'(first_viol_cycle);
`endif
  end
  task automatic cycle();
    @(posedge clk);
    #1;
    {rst, clr, req, ack, intr, seq_a, seq_b} = '0;
  endtask
  task automatic push(input int at, input int sel, input int val, input string nm);
    q.push_back('{at, sel, val, nm});
  endtask
  task automatic test_reset();
    rst = 1; req = 1; seq_a = 1;
    cycle();
    rst = 1; req = 1;
    cycle();
    checks += 6;
    if (pend !== 1'b0) begin failures++; $display("FAIL reset_pend got=%b exp=0", pend); end
    if (viol !== 1'b0) begin failures++; $display("FAIL reset_viol got=%b exp=0", viol); end
    if (cover_hit !== 1'b0) begin failures++; $display("FAIL reset_hit got=%b exp=0", cover_hit); end
    if (viol_cnt !== 2'd0) begin failures++; $display("FAIL reset_vcnt got=%0d exp=0", viol_cnt); end
    if (cover_cnt !== 2'd0) begin failures++; $display("FAIL reset_ccnt got=%0d exp=0", cover_cnt); end
    if (last_run !== 4'd0) begin failures++; $display("FAIL reset_last got=%0d exp=0", last_run); end
  endtask
  task automatic test_pass_and_viol();
    int t = cyc;
    req = 1; cycle();
    ack = 1; cycle();
    push(t + 1, PEND, 1, "pass_pend"); push(t + 2, VIOL, 0, "pass_viol"); push(t + 3, VIOL, 0, "pass_viol2"); push(t + 3, VCNT, 0, "pass_vcnt");
    cycle(); cycle();
    t = cyc;
    req = 1; cycle(); cycle(); cycle(); cycle(); cycle();
    push(t + 1, PEND, 1, "viol_pend"); push(t + 2, PEND, 0, "viol_pend_clr"); push(t + 1, VIOL, 0, "viol_early");
    push(t + 2, VIOL, 1, "viol_pulse"); push(t + 3, VIOL, 0, "viol_once"); push(t + 2, VCNT, 1, "viol_vcnt"); push(t + 4, VCNT, 1, "viol_vcnt_hold");
    while (q.size() != 0) begin
      e = q.pop_front(); checks++;
      if (e.at >= cyc || hist[e.at][e.sel] !== e.val) begin failures++; $display("FAIL %s cyc=%0d got=%0d exp=%0d", e.nm, e.at, hist[e.at][e.sel], e.val); end
    end
  endtask
  task automatic test_intr();
    int t = cyc;
    req = 1; cycle();
    intr = 1; cycle(); cycle(); cycle();
    push(t + 2, VIOL, 0, "intr_late_viol"); push(t + 3, VCNT, 1, "intr_late_vcnt");
    t = cyc;
    req = 1; intr = 1; cycle(); cycle(); cycle();
    push(t + 1, PEND, 0, "intr_early_pend"); push(t + 2, VIOL, 0, "intr_early_viol");
    while (q.size() != 0) begin
      e = q.pop_front(); checks++;
      if (e.at >= cyc || hist[e.at][e.sel] !== e.val) begin failures++; $display("FAIL %s cyc=%0d got=%0d exp=%0d", e.nm, e.at, hist[e.at][e.sel], e.val); end
    end
  endtask
  task automatic test_back_to_back();
    int t = cyc;
    req = 1; cycle();
    req = 1; ack = 1; cycle();
    req = 1; cycle();
    req = 1; ack = 1; cycle();
    cycle(); cycle();
    push(t + 2, VIOL, 0, "b2b_v2"); push(t + 3, VIOL, 1, "b2b_v3"); push(t + 4, VIOL, 0, "b2b_v4");
    push(t + 5, VIOL, 1, "b2b_v5"); push(t + 6, VIOL, 0, "b2b_v6"); push(t + 3, VCNT, 2, "b2b_vcnt2"); push(t + 5, VCNT, 3, "b2b_vcnt3");
    en = 0; req = 1; cycle();
    en = 1; req = 1; cycle();
    en = 0; cycle();
    en = 1; cycle(); cycle();
    push(t + 7, PEND, 0, "en_low_pend"); push(t + 8, VIOL, 0, "en_low_viol"); push(t + 8, PEND, 1, "en_armed_pend");
    push(t + 9, VIOL, 1, "en_armed_viol"); push(t + 9, VCNT, 3, "vcnt_sat");
    while (q.size() != 0) begin
      e = q.pop_front(); checks++;
      if (e.at >= cyc || hist[e.at][e.sel] !== e.val) begin failures++; $display("FAIL %s cyc=%0d got=%0d exp=%0d", e.nm, e.at, hist[e.at][e.sel], e.val); end
    end
  endtask
  task automatic test_clr();
    int t = cyc;
    req = 1; cycle();
    clr = 1; cycle(); cycle();
    req = 1; cycle(); cycle(); cycle();
    push(t + 2, VIOL, 1, "clr_viol_pulse"); push(t + 2, VCNT, 0, "clr_wins_vcnt"); push(t + 5, VCNT, 1, "clr_recount");
    while (q.size() != 0) begin
      e = q.pop_front(); checks++;
      if (e.at >= cyc || hist[e.at][e.sel] !== e.val) begin failures++; $display("FAIL %s cyc=%0d got=%0d exp=%0d", e.nm, e.at, hist[e.at][e.sel], e.val); end
    end
  endtask
  task automatic test_cover();
    int t = cyc;
    seq_a = 1; cycle();
    seq_a = 1; cycle();
    seq_b = 1; cycle();
    cycle();
    push(t + 3, HIT, 0, "short_run_hit"); push(t + 3, CCNT, 0, "short_run_ccnt");
    for (int i = 0; i < 4; i++) begin seq_a = 1; cycle(); end
    seq_b = 1; cycle(); cycle(); cycle();
    push(t + 8, HIT, 0, "run4_early"); push(t + 9, HIT, 1, "run4_hit"); push(t + 10, HIT, 0, "run4_once");
    push(t + 9, LAST, 4, "run4_last"); push(t + 9, CCNT, 1, "run4_ccnt");
    while (q.size() != 0) begin
      e = q.pop_front(); checks++;
      if (e.at >= cyc || hist[e.at][e.sel] !== e.val) begin failures++; $display("FAIL %s cyc=%0d got=%0d exp=%0d", e.nm, e.at, hist[e.at][e.sel], e.val); end
    end
  endtask
  task automatic test_overlap();
    int t = cyc;
    for (int i = 0; i < 5; i++) begin seq_a = 1; seq_b = i >= 3; cycle(); end
    seq_b = 1; cycle();
    seq_b = 1; cycle();
    cycle();
    push(t + 4, HIT, 1, "ovl_hit3"); push(t + 4, LAST, 3, "ovl_last3"); push(t + 4, CCNT, 2, "ovl_ccnt2");
    push(t + 5, LAST, 4, "ovl_last4"); push(t + 6, LAST, 5, "ovl_last5"); push(t + 6, CCNT, 3, "ccnt_sat");
    push(t + 7, HIT, 0, "idle_b_hit");
    t = cyc;
    for (int i = 0; i < 20; i++) begin seq_a = 1; cycle(); end
    seq_b = 1; cycle();
    clr = 1; cycle(); cycle();
    push(t + 21, HIT, 1, "runsat_hit"); push(t + 21, LAST, 15, "runsat_last");
    push(t + 22, LAST, 0, "clr_last"); push(t + 22, CCNT, 0, "clr_ccnt");
    while (q.size() != 0) begin
      e = q.pop_front(); checks++;
      if (e.at >= cyc || hist[e.at][e.sel] !== e.val) begin failures++; $display("FAIL %s cyc=%0d got=%0d exp=%0d", e.nm, e.at, hist[e.at][e.sel], e.val); end
    end
  endtask
  task automatic test_rst_mid();
    int t = cyc;
    req = 1; seq_a = 1; cycle();
    ack = 1; seq_a = 1; cycle();
    seq_a = 1; cycle();
    seq_a = 1; req = 1; cycle();
    rst = 1; seq_b = 1; cycle();
    rst_low = cyc;
    seq_b = 1; cycle(); cycle();
    push(t + 5, VIOL, 0, "rst_viol"); push(t + 6, VIOL, 0, "rst_viol2"); push(t + 5, PEND, 0, "rst_pend");
    push(t + 5, HIT, 0, "rst_hit"); push(t + 6, HIT, 0, "rst_hit2"); push(t + 5, LAST, 0, "rst_last");
    while (q.size() != 0) begin
      e = q.pop_front(); checks++;
      if (e.at >= cyc || hist[e.at][e.sel] !== e.val) begin failures++; $display("FAIL %s cyc=%0d got=%0d exp=%0d", e.nm, e.at, hist[e.at][e.sel], e.val); end
    end
  endtask
`ifdef FIRST_VIOL_STAMP_EN
  task automatic test_stamp();
    push(rst_low + 5, FVLD, 0, "stamp_vld0");
    while (cyc < rst_low + 8) cycle();
    req = 1; cycle();
    while (cyc < rst_low + 18) cycle();
    req = 1; cycle();
    while (cyc < rst_low + 24) cycle();
    clr = 1; cycle();
    while (cyc < rst_low + 28) cycle();
    req = 1; cycle(); cycle(); cycle(); cycle();
    push(rst_low + 11, FVLD, 1, "stamp_vld1"); push(rst_low + 11, FCYC, 10, "stamp_first");
    push(rst_low + 22, FCYC, 10, "stamp_hold"); push(rst_low + 25, FVLD, 0, "stamp_clr");
    push(rst_low + 31, FCYC, 30, "stamp_after_clr"); push(rst_low + 31, FVLD, 1, "stamp_vld2");
    while (q.size() != 0) begin
      e = q.pop_front(); checks++;
      if (e.at >= cyc || hist[e.at][e.sel] !== e.val) begin failures++; $display("FAIL %s cyc=%0d got=%0d exp=%0d", e.nm, e.at, hist[e.at][e.sel], e.val); end
    end
  endtask
`endif
  initial begin
    test_reset();
    test_pass_and_viol();
    test_intr();
    test_back_to_back();
    test_clr();
    test_cover();
    test_overlap();
    test_rst_mid();
`ifdef FIRST_VIOL_STAMP_EN
    test_stamp();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
